// File: rtl/dmem_banked.sv
// Banked scalar/vector data memory: LANES banks of ROWS x LANE_W, element a lives in
// bank a mod LANES, row a / LANES. Unaligned vectors take two rows over two cycles.
module dmem_banked #(
    parameter int unsigned LANE_W = 16,
    parameter int unsigned LANES  = 16,
    parameter int unsigned ROWS   = 1024,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic                    req_vec,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LANE_W-1:0]       req_wdata_s,
    input  logic [LANES*LANE_W-1:0] req_wdata_v,
    input  logic [LANES-1:0]        req_wmask,
    output logic                    rsp_valid,
    output logic [LANE_W-1:0]       rsp_rdata_s,
    output logic [LANES*LANE_W-1:0] rsp_rdata_v,
    output logic                    rsp_err
);

    localparam int unsigned BANK_W = $clog2(LANES);
    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam logic [ADDR_W-1:0] CAP      = ADDR_W'(ROWS * LANES);
    localparam logic [ADDR_W-1:0] VEC_LAST = ADDR_W'(ROWS * LANES - LANES);

    typedef enum logic {StIdle, StSplit} state_t;

    state_t state_q, state_d;
    logic   active_q;

    logic [LANE_W-1:0] mem     [LANES][ROWS];
    logic [LANE_W-1:0] stage_q [LANES];

    logic                    sp_we_q;
    logic [BANK_W-1:0]       sp_k_q;
    logic [ROW_W-1:0]        sp_row_q;
    logic [LANES*LANE_W-1:0] sp_wdata_q;
    logic [LANES-1:0]        sp_wmask_q;

    logic                    accept, req_err, in_split, go;
    logic [BANK_W-1:0]       req_bank, cur_k;
    logic [ROW_W-1:0]        req_row, cur_row;
    logic                    cur_we;
    logic [LANES*LANE_W-1:0] cur_wdata;
    logic [LANES-1:0]        cur_wmask;

    logic [ROW_W-1:0]        bank_row   [LANES];
    logic [BANK_W-1:0]       bank_elem  [LANES];
    logic [LANE_W-1:0]       bank_wdata [LANES];
    logic [LANE_W-1:0]       bank_rd    [LANES];
    logic [LANE_W-1:0]       bank_val   [LANES];
    logic [LANES-1:0]        bank_we;
    logic [LANES*LANE_W-1:0] rd_vec;

    assign req_ready = active_q && (state_q == StIdle);
    assign accept    = req_valid && req_ready;
    assign in_split  = (state_q == StSplit);
    assign req_bank  = req_addr[BANK_W-1:0];
    assign req_row   = req_addr[BANK_W +: ROW_W];
    // Vector bound compares the start address so addr+LANES-1 can never wrap.
    assign req_err   = req_vec ? (req_addr > VEC_LAST) : (req_addr >= CAP);
    assign go        = (accept && !req_err) || in_split;

    assign cur_we    = in_split ? sp_we_q    : req_we;
    assign cur_k     = in_split ? sp_k_q     : req_bank;
    assign cur_row   = in_split ? sp_row_q   : req_row;
    assign cur_wdata = in_split ? sp_wdata_q : req_wdata_v;
    assign cur_wmask = in_split ? sp_wmask_q : req_wmask;

    // Banks below k hold the tail of an unaligned vector in the next row.
    always_comb begin
        bank_we = '0;
        for (int b = 0; b < LANES; b++) begin
            bank_elem[b]  = BANK_W'(b) - cur_k;
            bank_row[b]   = (BANK_W'(b) < cur_k) ? cur_row + ROW_W'(1) : cur_row;
            bank_rd[b]    = mem[b][bank_row[b]];
            bank_val[b]   = (in_split && (BANK_W'(b) >= cur_k)) ? stage_q[b] : bank_rd[b];
            bank_wdata[b] = (req_vec || in_split) ?
                            cur_wdata[bank_elem[b]*LANE_W +: LANE_W] : req_wdata_s;
            if (go && cur_we) begin
                if (in_split) begin
                    bank_we[b] = (BANK_W'(b) < cur_k) && cur_wmask[bank_elem[b]];
                end else if (req_vec) begin
                    bank_we[b] = (BANK_W'(b) >= cur_k) && cur_wmask[bank_elem[b]];
                end else begin
                    bank_we[b] = (BANK_W'(b) == cur_k);
                end
            end
        end
    end

    always_comb begin
        rd_vec = '0;
        for (int e = 0; e < LANES; e++) begin
            rd_vec[e*LANE_W +: LANE_W] = bank_val[BANK_W'(BANK_W'(e) + cur_k)];
        end
    end

    always_comb begin
        state_d = StIdle;
        if (accept && req_vec && !req_err && (req_bank != '0)) begin
            state_d = StSplit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            active_q    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata_s <= '0;
            rsp_rdata_v <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= 1'b1;
            rsp_valid <= 1'b0;
            if (in_split) begin
                rsp_valid   <= 1'b1;
                rsp_err     <= 1'b0;
                rsp_rdata_s <= '0;
                rsp_rdata_v <= sp_we_q ? '0 : rd_vec;
            end else if (accept && (req_err || !req_vec || (req_bank == '0))) begin
                rsp_valid   <= 1'b1;
                rsp_err     <= req_err;
                rsp_rdata_s <= (req_err || req_we || req_vec) ? '0 : bank_val[req_bank];
                rsp_rdata_v <= (req_err || req_we || !req_vec) ? '0 : rd_vec;
            end
        end
    end

    // Memory and split context are deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            sp_we_q    <= req_we;
            sp_k_q     <= req_bank;
            sp_row_q   <= req_row;
            sp_wdata_q <= req_wdata_v;
            sp_wmask_q <= req_wmask;
            for (int b = 0; b < LANES; b++) begin
                stage_q[b] <= bank_rd[b];
            end
        end
        for (int b = 0; b < LANES; b++) begin
            if (bank_we[b]) begin
                mem[b][bank_row[b]] <= bank_wdata[b];
            end
        end
    end

endmodule
